// File: rtl/spi_frame_feeder.sv
// spi_frame_feeder: command stage in front of an SPI master.
//
// Transmit words are queued in a small FIFO. Each queued word launches one SPI frame.
// The feeder drives DI, pulses st for one clock, and then follows LOAD until the frame
// ends. When the frame ends, it captures the master's received word from DO.
//
// Parameters
//   M           SPI word width.
//   DEPTH_LOG2  FIFO address width; the FIFO holds 2**DEPTH_LOG2 words.
//   TMO         clocks allowed for LOAD to fall after st before err_tmo is raised.
//
// Ports
//   clk       system clock, rising edge
//   clr       synchronous active-high reset
//   wr_en     push wr_dat when the FIFO is not full
//   wr_dat    word to transmit
//   full      FIFO full (registered)
//   empty     FIFO empty (registered)
//   st        one-clock start pulse to the master
//   DI        transmit word; stable from st until the frame ends
//   LOAD      from master: low while a frame is in progress, high when idle
//   DO        received word from the master
//   rx_dat    last captured received word
//   rx_valid  one-clock strobe, coincident with a new rx_dat
//   busy      FSM is not idle
//   err_tmo   sticky start-timeout flag
//   frm_cnt   completed-frame counter, wraps 255 -> 0
module spi_frame_feeder #(
  parameter int unsigned M          = 15,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned TMO        = 255
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [M-1:0] wr_dat,
  output logic         full,
  output logic         empty,
  output logic         st,
  output logic [M-1:0] DI,
  input  logic         LOAD,
  input  logic [M-1:0] DO,
  output logic [M-1:0] rx_dat,
  output logic         rx_valid,
  output logic         busy,
  output logic         err_tmo,
  output logic [7:0]   frm_cnt
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  // The counter only has to reach TMO-1; the timeout fires on the following increment.
  localparam int unsigned TmoW  = (TMO < 2) ? 1 : $clog2(TMO);

  localparam logic [DEPTH_LOG2-1:0] PtrOne  = 1;
  localparam logic [DEPTH_LOG2:0]   CntOne  = 1;
  localparam logic [DEPTH_LOG2:0]   CntFull = Depth[DEPTH_LOG2:0];
  localparam logic [TmoW-1:0]       TmoLast = TmoW'(TMO - 1);
  localparam logic [TmoW-1:0]       TmoOne  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone,
    StCapture
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [M-1:0]          mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  full_q, empty_q;
  logic                  do_push, do_pop;

  state_e                state_q;

  assign do_push = wr_en & ~full_q;
  // A pop happens only on the IDLE->START step, and only while the master reports idle.
  assign do_pop  = (state_q == StIdle) & ~empty_q & LOAD;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntOne;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CntFull);
      empty_q <= (cnt_d == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  logic            st_q, rx_valid_q, err_q;
  logic [M-1:0]    di_q, rx_dat_q;
  logic [7:0]      frm_q;
  logic [TmoW-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      st_q       <= 1'b0;
      di_q       <= '0;
      rx_dat_q   <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      frm_q      <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      st_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (do_pop) begin
            di_q    <= mem[rd_ptr_q];
            st_q    <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          tmo_cnt_q <= '0;
          state_q   <= StWaitBusy;
        end
        StWaitBusy: begin
          if (!LOAD) begin
            state_q <= StWaitDone;
          end else if (tmo_cnt_q == TmoLast) begin
            // The master never accepted the frame, so the word is dropped.
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoOne;
          end
        end
        StWaitDone: begin
          // LOAD has been seen low, so LOAD high here is its rising edge.
          // DO is captured on this edge, so rx_dat and rx_valid appear together in CAPTURE.
          if (LOAD) begin
            rx_dat_q   <= DO;
            rx_valid_q <= 1'b1;
            frm_q      <= frm_q + 8'd1;
            state_q    <= StCapture;
          end
        end
        StCapture: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign st       = st_q;
  assign DI       = di_q;
  assign rx_dat   = rx_dat_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle);
  assign err_tmo  = err_q;
  assign frm_cnt  = frm_q;

endmodule

// File: tb/tb_spi_frame_feeder.sv
// Directed bench for spi_frame_feeder with a small behavioural SPI master model.
module tb_spi_frame_feeder;

  localparam int unsigned M   = 15;
  localparam int unsigned TMO = 255;
  localparam int          FL  = 6;  // frame length in clocks (LOAD low)
  localparam logic [M-1:0] SlaveDat = 15'h2AAA;

  logic         clk = 1'b0;
  logic         clr, wr_en;
  logic [M-1:0] wr_dat;
  logic         full, empty, st, LOAD, rx_valid, busy, err_tmo;
  logic [M-1:0] DI, DO, rx_dat;
  logic [7:0]   frm_cnt;

  always #5 clk = ~clk;

  spi_frame_feeder #(.M(M), .DEPTH_LOG2(2), .TMO(TMO)) dut (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_dat   (wr_dat),
    .full     (full),
    .empty    (empty),
    .st       (st),
    .DI       (DI),
    .LOAD     (LOAD),
    .DO       (DO),
    .rx_dat   (rx_dat),
    .rx_valid (rx_valid),
    .busy     (busy),
    .err_tmo  (err_tmo),
    .frm_cnt  (frm_cnt)
  );

  // Master model: LOAD drops after st, stays low FL clocks, then rises with DO valid.
  logic tie_high = 1'b0, hold_low = 1'b0;
  logic m_load = 1'b1;
  logic [M-1:0] m_do = '0;
  int m_left = 0;

  assign LOAD = tie_high ? 1'b1 : (hold_low ? 1'b0 : m_load);
  assign DO   = m_do;

  always @(posedge clk) begin
    if (st) begin
      m_load <= 1'b0;
      m_left <= FL;
      m_do   <= '0;
    end else if (!m_load && m_left > 0) begin
      if (m_left == 1) begin
        m_load <= 1'b1;
        m_do   <= SlaveDat;
      end
      m_left <= m_left - 1;
    end
  end

  // Monitor: log every launched word and count capture strobes.
  logic [M-1:0] st_log[$];
  int rx_n = 0;
  always @(posedge clk) begin
    if (st) st_log.push_back(DI);
    if (rx_valid) rx_n = rx_n + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [M-1:0] d);
    wr_en  = 1'b1;
    wr_dat = d;
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    while (!m_load && n < 50) begin
      tick();
      n++;
    end
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_frm(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (frm_cnt != 8'(target) && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_empty"}, 32'(empty), 32'd1);
    check_eq({pfx, "_full"}, 32'(full), 32'd0);
    check_eq({pfx, "_st"}, 32'(st), 32'd0);
    check_eq({pfx, "_di"}, 32'(DI), 32'd0);
    check_eq({pfx, "_rx_dat"}, 32'(rx_dat), 32'd0);
    check_eq({pfx, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_err"}, 32'(err_tmo), 32'd0);
    check_eq({pfx, "_frm"}, 32'(frm_cnt), 32'd0);
  endtask

  initial begin
    int st_base, rx_base, n, frm_at255;
    logic [M-1:0] exp_words[5];

    clr = 1'b1;
    wr_en = 1'b0;
    wr_dat = '0;
    @(negedge clk);
    do_reset();
    check_reset_outputs("rst");

    // 1: single word, latency and capture
    st_base = st_log.size();
    rx_base = rx_n;
    push(15'h1234);
    check_eq("t1_st_after_write", 32'(st), 32'd0);
    check_eq("t1_not_empty", 32'(empty), 32'd0);
    tick();
    check_eq("t1_st_pulse", 32'(st), 32'd1);
    check_eq("t1_di", 32'(DI), 32'h1234);
    tick();
    check_eq("t1_st_one_cycle", 32'(st), 32'd0);
    n = 0;
    while (!rx_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("t1_rx_seen", 32'(rx_valid), 32'd1);
    check_eq("t1_rx_dat", 32'(rx_dat), 32'(SlaveDat));
    check_eq("t1_frm", 32'(frm_cnt), 32'd1);
    tick();
    check_eq("t1_rx_strobe_len", 32'(rx_valid), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);
    check_eq("t1_rx_count", 32'(rx_n - rx_base), 32'd1);
    check_eq("t1_di_held", 32'(DI), 32'h1234);

    // 2: fill FIFO with master held busy, overflow write dropped
    do_reset();
    st_base = st_log.size();
    rx_base = rx_n;
    hold_low = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("t2_not_full_yet", 32'(full), 32'd0);
      push(M'(i));
    end
    check_eq("t2_full", 32'(full), 32'd1);
    push(15'h7FFF);
    check_eq("t2_still_full", 32'(full), 32'd1);
    check_eq("t2_no_st_while_busy", 32'(st_log.size() - st_base), 32'd0);
    hold_low = 1'b0;
    wait_frm("t2_frames_done", 4, 300);
    repeat (20) tick();
    check_eq("t2_frm", 32'(frm_cnt), 32'd4);
    check_eq("t2_empty", 32'(empty), 32'd1);
    check_eq("t2_st_count", 32'(st_log.size() - st_base), 32'd4);
    check_eq("t2_rx_count", 32'(rx_n - rx_base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (st_base + i < st_log.size()) begin
        check_eq("t2_order", 32'(st_log[st_base + i]), 32'(i + 1));
      end
    end

    // 3: start timeout with LOAD stuck high
    do_reset();
    st_base = st_log.size();
    rx_base = rx_n;
    tie_high = 1'b1;
    push(15'h0055);
    n = 0;
    while (!st && n < 10) begin
      tick();
      n++;
    end
    check_eq("t3_st_seen", 32'(st), 32'd1);
    repeat (TMO) tick();
    check_eq("t3_err_not_yet", 32'(err_tmo), 32'd0);
    check_eq("t3_busy_before", 32'(busy), 32'd1);
    tick();
    check_eq("t3_err_set", 32'(err_tmo), 32'd1);
    check_eq("t3_idle", 32'(busy), 32'd0);
    repeat (5) tick();
    check_eq("t3_err_sticky", 32'(err_tmo), 32'd1);
    check_eq("t3_frm", 32'(frm_cnt), 32'd0);
    check_eq("t3_no_rx", 32'(rx_n - rx_base), 32'd0);
    check_eq("t3_one_st", 32'(st_log.size() - st_base), 32'd1);
    check_eq("t3_empty", 32'(empty), 32'd1);
    tie_high = 1'b0;

    // 4: reset during WAIT_DONE with two words queued
    do_reset();
    st_base = st_log.size();
    rx_base = rx_n;
    push(15'h0101);
    push(15'h0202);
    push(15'h0303);
    n = 0;
    while (LOAD && n < 20) begin
      tick();
      n++;
    end
    check_eq("t4_load_low", 32'(LOAD), 32'd0);
    tick();
    check_eq("t4_busy_pre", 32'(busy), 32'd1);
    check_eq("t4_not_empty_pre", 32'(empty), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_reset_outputs("t4");
    n = 0;
    while (!LOAD && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_eq("t4_no_rx", 32'(rx_n - rx_base), 32'd0);
    check_eq("t4_frm", 32'(frm_cnt), 32'd0);
    check_eq("t4_no_new_st", 32'(st_log.size() - st_base), 32'd1);

    // 5: 256 frames, counter wrap
    do_reset();
    st_base = st_log.size();
    rx_base = rx_n;
    frm_at255 = -1;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (full && n < 100) begin
        tick();
        n++;
      end
      push(M'(i));
    end
    n = 0;
    while ((rx_n - rx_base) < 256 && n < 5000) begin
      if ((rx_n - rx_base) == 255 && frm_at255 < 0) frm_at255 = int'(frm_cnt);
      tick();
      n++;
    end
    repeat (3) tick();
    check_eq("t5_rx_count", 32'(rx_n - rx_base), 32'd256);
    check_eq("t5_frm_255", 32'(frm_at255), 32'd255);
    check_eq("t5_frm_wrap", 32'(frm_cnt), 32'd0);
    check_eq("t5_st_count", 32'(st_log.size() - st_base), 32'd256);
    if (st_log.size() >= st_base + 256) begin
      check_eq("t5_last_word", 32'(st_log[st_base + 255]), 32'd255);
    end

    // 6: write coincident with pop while FIFO holds one word
    do_reset();
    st_base = st_log.size();
    exp_words[0] = 15'h0A0A;
    exp_words[1] = 15'h0B0B;
    exp_words[2] = 15'h0C0C;
    exp_words[3] = 15'h0D0D;
    exp_words[4] = 15'h0E0E;
    hold_low = 1'b1;
    push(exp_words[0]);
    hold_low = 1'b0;
    push(exp_words[1]);
    check_eq("t6_st", 32'(st), 32'd1);
    check_eq("t6_di", 32'(DI), 32'(exp_words[0]));
    check_eq("t6_not_empty", 32'(empty), 32'd0);
    push(exp_words[2]);
    push(exp_words[3]);
    check_eq("t6_cnt3_not_full", 32'(full), 32'd0);
    push(exp_words[4]);
    check_eq("t6_cnt4_full", 32'(full), 32'd1);
    wait_frm("t6_frames_done", 5, 300);
    repeat (3) tick();
    check_eq("t6_st_count", 32'(st_log.size() - st_base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (st_base + i < st_log.size()) begin
        check_eq("t6_order", 32'(st_log[st_base + i]), 32'(exp_words[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
